// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: dual-port word memory serving the core's instruction and
// data ports, with a parameterised read latency (1..4) and rvalid strobes.
// Optional macro ADDR_ERR_EN: range-check upper address bits, suppress
// out-of-range writes, return 32'hDEAD_BEEF on out-of-range reads and raise
// a sticky addr_err flag.
module cpu_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        inst_en,
    input  logic [3:0]  inst_we,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    input  logic        data_en,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] inst_idx, data_idx;
    logic                  inst_ok, data_ok;
    logic                  inst_rd, data_rd, inst_wr, data_wr;
    logic [31:0]           inst_word, data_word;

    logic                  inst_pv [READ_LATENCY];
    logic [31:0]           inst_pd [READ_LATENCY];
    logic                  data_pv [READ_LATENCY];
    logic [31:0]           data_pd [READ_LATENCY];

    // Byte offset bits are never used; the ports are always word-aligned.
    logic unused_low_bits;
    assign unused_low_bits = ^{inst_addr[1:0], data_addr[1:0]};

    assign inst_idx = inst_addr[ADDR_WIDTH+1:2];
    assign data_idx = data_addr[ADDR_WIDTH+1:2];

`ifdef ADDR_ERR_EN
    assign inst_ok = (inst_addr[31:ADDR_WIDTH+2] == '0);
    assign data_ok = (data_addr[31:ADDR_WIDTH+2] == '0);
`else
    // Addresses wrap modulo depth; upper bits are discarded.
    logic unused_high_bits;
    assign unused_high_bits = ^{inst_addr[31:ADDR_WIDTH+2], data_addr[31:ADDR_WIDTH+2]};
    assign inst_ok = 1'b1;
    assign data_ok = 1'b1;
`endif

    assign inst_rd = inst_en && (inst_we == '0);
    assign data_rd = data_en && (data_we == '0);
    assign inst_wr = inst_en && (inst_we != '0) && inst_ok;
    assign data_wr = data_en && (data_we != '0) && data_ok;

    // Reads sample the array before this edge's writes land: read-first.
    assign inst_word = inst_ok ? mem[inst_idx] : 32'hDEAD_BEEF;
    assign data_word = data_ok ? mem[data_idx] : 32'hDEAD_BEEF;

    // Byte-lane writes; data port's assignment comes last so it wins shared lanes.
    always_ff @(posedge aclk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (inst_wr && inst_we[b]) mem[inst_idx][8*b +: 8] <= inst_wdata[8*b +: 8];
            if (data_wr && data_we[b]) mem[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
        end
    end

    // Read latency pipelines; data stages only load on valid so rdata holds.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                inst_pv[i] <= 1'b0;
                inst_pd[i] <= '0;
                data_pv[i] <= 1'b0;
                data_pd[i] <= '0;
            end
        end else begin
            inst_pv[0] <= inst_rd;
            data_pv[0] <= data_rd;
            if (inst_rd) inst_pd[0] <= inst_word;
            if (data_rd) data_pd[0] <= data_word;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                inst_pv[i] <= inst_pv[i-1];
                data_pv[i] <= data_pv[i-1];
                if (inst_pv[i-1]) inst_pd[i] <= inst_pd[i-1];
                if (data_pv[i-1]) data_pd[i] <= data_pd[i-1];
            end
        end
    end

    assign inst_rvalid = inst_pv[READ_LATENCY-1];
    assign inst_rdata  = inst_pd[READ_LATENCY-1];
    assign data_rvalid = data_pv[READ_LATENCY-1];
    assign data_rdata  = data_pd[READ_LATENCY-1];

`ifdef ADDR_ERR_EN
    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_err <= 1'b0;
        end else if ((inst_en && !inst_ok) || (data_en && !data_ok)) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed steps plus randomized traffic, checked every
// cycle against a queue-based reference model of the memory.
module tb_cpu_mem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic        aclk = 1'b0;
    logic        areset;
    logic        inst_en, data_en;
    logic [3:0]  inst_we, data_we;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_rvalid, data_rvalid, addr_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    cpu_mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
        .aclk(aclk), .areset(areset),
        .inst_en(inst_en), .inst_we(inst_we), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
        .data_en(data_en), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
        .addr_err(addr_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int unsigned due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] mdl [DEPTH];
    rd_t         q_i[$], q_d[$];
    logic [31:0] last_i = '0, last_d = '0;
    logic        exp_err = 1'b0;
    int unsigned cyc = 0;

    function automatic logic oob(input logic [31:0] a);
`ifdef ADDR_ERR_EN
        return (a >> (AW + 2)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
                         input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        inst_en = ie; inst_we = iw; inst_addr = ia; inst_wdata = id;
        data_en = de; data_we = dw; data_addr = da; data_wdata = dd;
    endtask

    // One clock: update the model from the driven inputs, then check all outputs.
    task automatic cycle();
        rd_t r;
        logic ev;
        if (!areset) begin
            if (inst_en && inst_we == 4'h0) begin
                r.due = cyc + LAT;
                r.d = oob(inst_addr) ? 32'hDEAD_BEEF : mdl[widx(inst_addr)];
                q_i.push_back(r);
            end
            if (data_en && data_we == 4'h0) begin
                r.due = cyc + LAT;
                r.d = oob(data_addr) ? 32'hDEAD_BEEF : mdl[widx(data_addr)];
                q_d.push_back(r);
            end
            for (int b = 0; b < 4; b++) begin
                if (inst_en && inst_we[b] && !oob(inst_addr))
                    mdl[widx(inst_addr)][8*b +: 8] = inst_wdata[8*b +: 8];
            end
            for (int b = 0; b < 4; b++) begin
                if (data_en && data_we[b] && !oob(data_addr))
                    mdl[widx(data_addr)][8*b +: 8] = data_wdata[8*b +: 8];
            end
            if ((inst_en && oob(inst_addr)) || (data_en && oob(data_addr))) exp_err = 1'b1;
        end
        @(posedge aclk);
        #1;
        cyc++;
        ev = 1'b0;
        if (q_i.size() > 0 && q_i[0].due == cyc) begin
            ev = 1'b1; last_i = q_i[0].d; void'(q_i.pop_front());
        end
        chk("inst_rvalid", {31'b0, inst_rvalid}, {31'b0, ev});
        chk("inst_rdata", inst_rdata, last_i);
        ev = 1'b0;
        if (q_d.size() > 0 && q_d[0].due == cyc) begin
            ev = 1'b1; last_d = q_d[0].d; void'(q_d.pop_front());
        end
        chk("data_rvalid", {31'b0, data_rvalid}, {31'b0, ev});
        chk("data_rdata", data_rdata, last_d);
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
            cycle();
        end
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = {20'h0, 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
        if ($urandom_range(0, 15) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
        return a;
    endfunction

    initial begin
        logic [31:0] w0_before;
        logic        ie, de;
        logic [3:0]  iw, dw;

        areset = 1'b1;
        drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
        idle(2);
        areset = 1'b0;
        idle(1);

        // Preload the region used by the random phase.
        for (int unsigned w = 0; w < 64; w++) begin
            drive(0, 4'h0, '0, '0, 1, 4'hF, w << 2, $urandom);
            cycle();
        end

        // Data-port write, then instruction-port read of the same word.
        drive(0, 4'h0, '0, '0, 1, 4'hF, 32'h10, 32'h1122_3344); cycle();
        drive(1, 4'h0, 32'h10, '0, 0, 4'h0, '0, '0); cycle();
        idle(LAT - 1);
        chk("t2_rvalid", {31'b0, inst_rvalid}, 32'd1);
        chk("t2_rdata", inst_rdata, 32'h1122_3344);

        // Single byte-lane update.
        drive(0, 4'h0, '0, '0, 1, 4'hF, 32'h20, 32'hAABB_CCDD); cycle();
        drive(0, 4'h0, '0, '0, 1, 4'b0001, 32'h20, 32'h0000_00EE); cycle();
        drive(0, 4'h0, '0, '0, 1, 4'h0, 32'h20, '0); cycle();
        idle(LAT - 1);
        chk("t3_rdata", data_rdata, 32'hAABB_CCEE);

        // Simultaneous writes from both ports to one word.
        drive(0, 4'h0, '0, '0, 1, 4'hF, 32'h40, 32'h0); cycle();
        drive(1, 4'b0011, 32'h40, 32'h1111_1111, 1, 4'b0110, 32'h40, 32'h2222_2222); cycle();
        drive(1, 4'h0, 32'h40, '0, 0, 4'h0, '0, '0); cycle();
        idle(LAT - 1);
        chk("t4_rdata", inst_rdata, 32'h0022_2211);

        // Cross-port read-during-write returns the old word.
        drive(0, 4'h0, '0, '0, 1, 4'hF, 32'h80, 32'h5); cycle();
        drive(1, 4'h0, 32'h80, '0, 1, 4'hF, 32'h80, 32'h9); cycle();
        idle(LAT - 1);
        chk("t5_old", inst_rdata, 32'h5);
        drive(1, 4'h0, 32'h80, '0, 0, 4'h0, '0, '0); cycle();
        idle(LAT - 1);
        chk("t5_new", inst_rdata, 32'h9);

        // Reset mid-stream drops an in-flight read.
        drive(1, 4'h0, 32'h10, '0, 1, 4'h0, 32'h20, '0); cycle();
        drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0);
        #2;
        areset = 1'b1;
        q_i.delete(); q_d.delete();
        last_i = '0; last_d = '0; exp_err = 1'b0;
        #1;
        chk("rst_inst_rvalid", {31'b0, inst_rvalid}, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        idle(2);
        areset = 1'b0;
        idle(LAT + 2);
        drive(1, 4'h0, 32'h10, '0, 0, 4'h0, '0, '0); cycle();
        idle(LAT - 1);
        chk("post_rst_rdata", inst_rdata, 32'h1122_3344);

        // Out-of-range access (wraps to word 0 without the range check).
        w0_before = mdl[0];
        chk("t6_err_before", {31'b0, addr_err}, 32'd0);
        drive(0, 4'h0, '0, '0, 1, 4'hF, 32'h0000_1000, 32'h1234_5678); cycle();
        drive(0, 4'h0, '0, '0, 1, 4'h0, 32'h0000_1000, '0); cycle();
        idle(LAT - 1);
`ifdef ADDR_ERR_EN
        chk("t6_err", {31'b0, addr_err}, 32'd1);
        chk("t6_oob_rdata", data_rdata, 32'hDEAD_BEEF);
`else
        chk("t6_err", {31'b0, addr_err}, 32'd0);
        chk("t6_wrap_rdata", data_rdata, 32'h1234_5678);
`endif
        drive(0, 4'h0, '0, '0, 1, 4'h0, 32'h0, '0); cycle();
        idle(LAT - 1);
`ifdef ADDR_ERR_EN
        chk("t6_word0", data_rdata, w0_before);
`else
        chk("t6_word0", data_rdata, 32'h1234_5678);
`endif

        // Randomized traffic on both ports.
        for (int unsigned n = 0; n < 400; n++) begin
            ie = ($urandom_range(0, 3) != 0);
            de = ($urandom_range(0, 3) != 0);
            iw = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            dw = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            drive(ie, iw, raddr(), $urandom, de, dw, raddr(), $urandom);
            cycle();
        end
        idle(LAT + 1);
        chk("drain_inst", q_i.size(), 32'd0);
        chk("drain_data", q_d.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
